// File: rtl/can_frame_tx.sv
// CAN 2.0A standard-frame transmitter: serialises SOF through intermission one bit per
// BIT_TICK, with bit stuffing and CRC-15 generation, and checks the ACK slot.
module can_frame_tx #(
    parameter int IFS_BITS = 3
) (
    input  logic        clock,
    input  logic        CLEAR,
    input  logic        BIT_TICK,
    input  logic        START,
    input  logic [10:0] ID,
    input  logic        RTR,
    input  logic [3:0]  DLC,
    input  logic [63:0] DATA,
    input  logic        RXBIT,
    output logic        TXBIT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ACK_ERR
);

    localparam logic [14:0] CRC_POLY = 15'h4599;

    // Each state names the field whose next bit goes out on the coming BIT_TICK.
    typedef enum logic [3:0] {
        S_IDLE,
        S_SOF,
        S_ID,
        S_RTR,
        S_IDE,
        S_R0,
        S_DLC,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK,
        S_ACK_DEL,
        S_EOF,
        S_IFS,
        S_END
    } state_t;

    state_t      state;
    state_t      next_field;
    logic [10:0] id_q;
    logic        rtr_q;
    logic [3:0]  dlc_q;
    logic [63:0] data_q;
    logic [6:0]  data_bits;
    logic [6:0]  cnt;
    logic [6:0]  field_len;
    logic [14:0] crc;
    logic [14:0] crc_next;
    logic [2:0]  run_len;
    logic        last_bit;
    logic        field_bit;
    logic        field_last;
    logic        stuff_zone;
    logic        crc_zone;
    logic        stuff_due;
    logic        crc_inv;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        field_bit  = 1'b1;
        field_len  = 7'd1;
        next_field = S_IDLE;
        case (state)
            S_SOF: begin
                field_bit  = 1'b0;
                next_field = S_ID;
            end
            S_ID: begin
                field_bit  = id_q[4'd10 - cnt[3:0]];
                field_len  = 7'd11;
                next_field = S_RTR;
            end
            S_RTR: begin
                field_bit  = rtr_q;
                next_field = S_IDE;
            end
            S_IDE: begin
                field_bit  = 1'b0;
                next_field = S_R0;
            end
            S_R0: begin
                field_bit  = 1'b0;
                next_field = S_DLC;
            end
            S_DLC: begin
                field_bit  = dlc_q[2'd3 - cnt[1:0]];
                field_len  = 7'd4;
                next_field = (data_bits == 7'd0) ? S_CRC : S_DATA;
            end
            S_DATA: begin
                field_bit  = data_q[6'd63 - cnt[5:0]];
                field_len  = data_bits;
                next_field = S_CRC;
            end
            S_CRC: begin
                field_bit  = crc[4'd14 - cnt[3:0]];
                field_len  = 7'd15;
                next_field = S_CRC_DEL;
            end
            S_CRC_DEL: next_field = S_ACK;
            S_ACK:     next_field = S_ACK_DEL;
            S_ACK_DEL: next_field = S_EOF;
            S_EOF: begin
                field_len  = 7'd7;
                next_field = (IFS_BITS == 0) ? S_END : S_IFS;
            end
            S_IFS: begin
                field_len  = 7'(IFS_BITS);
                next_field = S_END;
            end
            default: next_field = S_IDLE;
        endcase
    end

    assign field_last = (cnt == field_len - 7'd1);
    assign stuff_zone = state inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
    assign crc_zone   = state inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA};
    // A run completed on the last CRC bit still owes its stuff bit ahead of the delimiter.
    assign stuff_due  = (stuff_zone || state == S_CRC_DEL) && (run_len == 3'd5);
    assign crc_inv    = field_bit ^ crc[14];
    assign crc_next   = {crc[13:0], 1'b0} ^ (crc_inv ? CRC_POLY : 15'h0000);

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge CLEAR) begin
        if (CLEAR) begin
            state     <= S_IDLE;
            id_q      <= '0;
            rtr_q     <= 1'b0;
            dlc_q     <= '0;
            data_q    <= '0;
            data_bits <= '0;
            cnt       <= '0;
            crc       <= '0;
            run_len   <= '0;
            last_bit  <= 1'b1;
            TXBIT     <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ACK_ERR   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (state == S_IDLE) begin
                if (START) begin
                    id_q      <= ID;
                    rtr_q     <= RTR;
                    dlc_q     <= DLC;
                    data_q    <= DATA;
                    data_bits <= RTR    ? 7'd0 :
                                 DLC[3] ? 7'd64 : {1'b0, DLC[2:0], 3'b000};
                    cnt       <= '0;
                    crc       <= '0;
                    run_len   <= '0;
                    BUSY      <= 1'b1;
                    ACK_ERR   <= 1'b0;
                    state     <= S_SOF;
                end
            end else if (BIT_TICK) begin
                if (state == S_END) begin
                    TXBIT <= 1'b1;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= S_IDLE;
                end else if (stuff_due) begin
                    TXBIT    <= ~last_bit;
                    last_bit <= ~last_bit;
                    run_len  <= 3'd1;
                end else begin
                    TXBIT <= field_bit;
                    if (stuff_zone) begin
                        last_bit <= field_bit;
                        run_len  <= (run_len != 3'd0 && field_bit == last_bit) ? run_len + 3'd1 : 3'd1;
                    end
                    if (crc_zone) begin
                        crc <= crc_next;
                    end
                    // This tick closes the ACK slot, so it is where the bus level is judged.
                    if (state == S_ACK_DEL && RXBIT) begin
                        ACK_ERR <= 1'b1;
                    end
                    if (field_last) begin
                        cnt   <= '0;
                        state <= next_field;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_can_frame_tx.sv
// Bench for can_frame_tx: a frame model builds the expected stuffed bit stream into a
// scoreboard queue at START, and each BIT_TICK pops and compares TXBIT.
module tb_can_frame_tx;

    localparam int IFS = 3;

    logic        clock = 1'b0;
    logic        CLEAR;
    logic        BIT_TICK;
    logic        START;
    logic [10:0] ID;
    logic        RTR;
    logic [3:0]  DLC;
    logic [63:0] DATA;
    logic        RXBIT;
    logic        TXBIT;
    logic        BUSY;
    logic        DONE;
    logic        ACK_ERR;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];
    bit cap[$];

    can_frame_tx #(.IFS_BITS(IFS)) dut (
        .clock    (clock),
        .CLEAR    (CLEAR),
        .BIT_TICK (BIT_TICK),
        .START    (START),
        .ID       (ID),
        .RTR      (RTR),
        .DLC      (DLC),
        .DATA     (DATA),
        .RXBIT    (RXBIT),
        .TXBIT    (TXBIT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ACK_ERR  (ACK_ERR)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input bit tick);
        BIT_TICK = tick;
        @(posedge clock);
        #1;
        BIT_TICK = 1'b0;
    endtask

    // Unstuffed frame -> CRC -> stuffing pass -> fixed recessive tail.
    task automatic build_expected(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                                  input logic [63:0] data, output int stuffed_len);
        bit          raw[$];
        logic [14:0] crc;
        bit          inv;
        bit          last;
        int          run;
        int          nbits;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : 8 * int'(dlc));
        for (int i = 0; i < nbits; i++) raw.push_back(data[63-i]);
        crc = '0;
        foreach (raw[i]) begin
            inv = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (inv) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        exp_q.delete();
        run  = 0;
        last = 1'b0;
        foreach (raw[i]) begin
            exp_q.push_back(raw[i]);
            if (run > 0 && raw[i] == last) run++;
            else run = 1;
            last = raw[i];
            if (run == 5) begin
                exp_q.push_back(!last);
                last = !last;
                run  = 1;
            end
        end
        stuffed_len = exp_q.size();
        repeat (10 + IFS) exp_q.push_back(1'b1);
    endtask

    task automatic run_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input logic ack_lvl, input bit with_tick,
                             input bit mid_start, input bit b2b, output int done_tick);
        int slen;
        int tick_no;
        bit done_seen;
        build_expected(id, rtr, dlc, data, slen);
        cap.delete();
        ID = id; RTR = rtr; DLC = dlc; DATA = data;
        START = 1'b1;
        step(with_tick);
        START = 1'b0;
        check("busy_on_start", BUSY, 1);
        check("ack_err_cleared", ACK_ERR, 0);
        check("tx_recessive_after_start", TXBIT, 1);
        tick_no   = 0;
        done_seen = 1'b0;
        done_tick = -1;
        while (!done_seen && tick_no < 400) begin
            step(1'b1);
            tick_no++;
            if (DONE) begin
                done_seen = 1'b1;
                done_tick = tick_no - 1;
                check("done_tick", tick_no, slen + 10 + IFS + 1);
                check("queue_empty_at_done", exp_q.size(), 0);
                check("tx_at_done", TXBIT, 1);
                check("busy_at_done", BUSY, 0);
            end else begin
                cap.push_back(TXBIT);
                if (exp_q.size() > 0)
                    check($sformatf("txbit[%0d]", tick_no - 1), TXBIT, exp_q.pop_front());
                else
                    check("frame_too_long", tick_no, slen + 10 + IFS + 1);
                RXBIT = (tick_no == slen + 2) ? ack_lvl : 1'b0;
                if (mid_start && tick_no == 5) begin
                    START = 1'b1; ID = ~id; RTR = ~rtr; DLC = ~dlc; DATA = ~data;
                end
                step(1'b0);
                START = 1'b0; ID = id; RTR = rtr; DLC = dlc; DATA = data;
                step(1'b0);
                step(1'b0);
            end
        end
        RXBIT = 1'b0;
        if (!done_seen) check("done_timeout", 0, 1);
        if (!b2b) begin
            step(1'b0);
            check("done_one_pulse", DONE, 0);
        end
    endtask

    initial begin
        int dt;
        int slen;
        int tick_no;
        CLEAR = 1'b1; BIT_TICK = 1'b0; START = 1'b0; RXBIT = 1'b0;
        ID = '0; RTR = 1'b0; DLC = '0; DATA = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_txbit", TXBIT, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_ack_err", ACK_ERR, 0);
        CLEAR = 1'b0;
        step(1'b1);
        check("idle_tick_txbit", TXBIT, 1);

        // All-zero frame: six stuff ones, 53 tick intervals.
        run_frame(11'h000, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, dt);
        check("zero_frame_ticks", dt, 53);
        check("zero_frame_ack_err", ACK_ERR, 0);

        // All-ones identifier: stuff zeros after ID[6] and ID[1].
        run_frame(11'h7FF, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, dt);
        if (cap.size() > 12) begin
            check("stuff_after_id6", cap[6], 0);
            check("stuff_after_id1", cap[12], 0);
        end else check("ones_frame_short", cap.size(), 13);

        // Full payload, recessive ACK, START pulsed mid-frame.
        run_frame(11'h123, 1'b0, 4'd8, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b1, 1'b0, dt);
        check("ack_err_set", ACK_ERR, 1);

        // Remote frame with DLC 15, then DLC 12 data frame; the START clears ACK_ERR.
        run_frame(11'h555, 1'b1, 4'd15, 64'hFFFF_0000_AAAA_5555, 1'b0, 1'b0, 1'b0, 1'b0, dt);
        check("rtr_frame_ack_err", ACK_ERR, 0);
        run_frame(11'h2A6, 1'b0, 4'd12, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0, dt);

        // CLEAR during the data field.
        build_expected(11'h123, 1'b0, 4'd8, 64'h0123456789ABCDEF, slen);
        ID = 11'h123; RTR = 1'b0; DLC = 4'd8; DATA = 64'h0123456789ABCDEF;
        START = 1'b1;
        step(1'b0);
        START = 1'b0;
        tick_no = 0;
        while (tick_no < 80 && !(tick_no >= 30 && TXBIT == 1'b0)) begin
            step(1'b1);
            tick_no++;
            if (exp_q.size() > 0) check("txbit_pre_clear", TXBIT, exp_q.pop_front());
            step(1'b0);
            step(1'b0);
        end
        check("clear_point_dominant", TXBIT, 0);
        #2 CLEAR = 1'b1;
        #1;
        check("clear_async_txbit", TXBIT, 1);
        check("clear_busy", BUSY, 0);
        check("clear_done", DONE, 0);
        @(posedge clock);
        #1;
        CLEAR = 1'b0;
        exp_q.delete();
        repeat (8) begin
            step(1'b1);
            check("post_clear_done", DONE, 0);
            check("post_clear_txbit", TXBIT, 1);
            step(1'b0);
            step(1'b0);
        end

        // START coincident with a tick, then back-to-back frames.
        run_frame(11'h0F0, 1'b0, 4'd2, 64'hC3A5_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, dt);
        run_frame(11'h7C1, 1'b0, 4'd1, 64'h1F00_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, dt);
        check("b2b_ack_err", ACK_ERR, 1);
        run_frame(11'h3FF, 1'b0, 4'd3, 64'hFFFF_FF00_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, dt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
